datapath_regs: RTL and testbench

DATAPATH_REGS -- requirements
Module: datapath_regs

---
 rtl/datapath_regs_pkg.sv | 26 ++
 rtl/datapath_regs_counter.sv | 43 ++++
 rtl/datapath_regs.sv | 126 ++++++++++++
 tb/tb_datapath_regs.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_regs_pkg.sv
// Shared constants for the register-file datapath: widths, bus select codes,
// special register indices and flag bit positions.
package datapath_regs_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;
  localparam int NUM_R  = 8;

  // Bus source select codes. Codes 0..7 select R0..R7 and 11..15 drive zero.
  localparam logic [3:0] SEL_IR  = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;
  localparam logic [3:0] SEL_DIN = 4'd10;

  // Registers with counting behaviour.
  localparam int PC_IDX = 7;
  localparam int SP_IDX = 5;

  // Bit positions inside the {cout, n, z} flag vector.
  localparam int FLAG_COUT = 2;
  localparam int FLAG_N    = 1;
  localparam int FLAG_Z    = 0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [FLAG_W-1:0] flags_t;

endpackage : datapath_regs_pkg

// File: rtl/datapath_regs_counter.sv
// 16-bit register with parallel load, increment and decrement. Load wins over
// counting; simultaneous inc and dec cancel out and the register holds.
module up_down_counter_reg
  import datapath_regs_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load_i,
  input  word_t data_i,
  input  logic  inc_i,
  input  logic  dec_i,
  output word_t q_o
);

  word_t cnt_q;
  word_t cnt_d;

  // Next-state selection: load, then single-direction count, otherwise hold.
  always_comb begin
    // NOTE: assigning a default first means every path writes cnt_d, so no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = data_i;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + word_t'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - word_t'(1);
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule : up_down_counter_reg

// File: rtl/datapath_regs.sv
// Register file and special-purpose registers of a simple processor datapath.
// All load enables are active-low; the internal bus is a pure mux over the
// register outputs, so loading a register from itself simply holds its value.
module datapath_regs
  import datapath_regs_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_R-1:0]    RX_in,
  input  logic                IR_in,
  input  logic                A_in,
  input  logic                G_in,
  input  logic                ADDR_in,
  input  logic                DOUT_in,
  input  logic                flag_in,
  input  logic                pc_incr,
  input  logic                sp_incr,
  input  logic                sp_decr,
  input  logic                W_inp,
  input  logic [3:0]          sel,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic [DATA_W-1:0]   bus,
  output logic [DATA_W-1:0]   IR_out,
  output logic [DATA_W-1:0]   A_out,
  output logic [DATA_W-1:0]   G_out,
  output logic [DATA_W-1:0]   addr_out,
  output logic [DATA_W-1:0]   dout_out,
  output logic [FLAG_W-1:0]   flag_out,
  output logic                w_out,
  output logic [DATA_W-1:0]   pc_out
);

  word_t  r_val [NUM_R];
  word_t  ir_q, a_q, g_q, addr_q, dout_q;
  flags_t flag_q;
  logic   w_q;

  // General registers R0..R7; SP and PC get the counting register.
  for (genvar n = 0; n < NUM_R; n++) begin : g_r
    if (n == SP_IDX) begin : g_sp
      up_down_counter_reg u_sp (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (!RX_in[n]),
        .data_i  (bus),
        .inc_i   (sp_incr),
        .dec_i   (sp_decr),
        .q_o     (r_val[n])
      );
    end else if (n == PC_IDX) begin : g_pc
      up_down_counter_reg u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (!RX_in[n]),
        .data_i  (bus),
        .inc_i   (pc_incr),
        .dec_i   (1'b0),
        .q_o     (r_val[n])
      );
    end else begin : g_plain
      word_t r_q;

      // Plain register: load from the bus when enabled, else hold.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_q <= '0;
        end else if (!RX_in[n]) begin
          r_q <= bus;
        end
      end

      assign r_val[n] = r_q;
    end
  end

  // Bus source mux; unused codes drive zero.
  always_comb begin
    bus = '0;
    case (sel)
      SEL_IR:  bus = {7'b0, ir_q[8:0]};
      SEL_G:   bus = g_q;
      SEL_DIN: bus = din;
      default: if (!sel[3]) bus = r_val[sel[2:0]];
    endcase
  end

  // Special registers: IR from memory, G from the ALU, the rest from the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      flag_q <= '0;
    end else begin
      if (!IR_in)   ir_q   <= din;
      if (!A_in)    a_q    <= bus;
      if (!G_in)    g_q    <= alu_result;
      if (!ADDR_in) addr_q <= bus;
      if (!DOUT_in) dout_q <= bus;
      if (!flag_in) flag_q <= alu_flags;
    end
  end

  // Memory write strobe, delayed one cycle to line up with ADDR/DOUT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q <= 1'b0;
    end else begin
      w_q <= W_inp;
    end
  end

  assign IR_out   = ir_q;
  assign A_out    = a_q;
  assign G_out    = g_q;
  assign addr_out = addr_q;
  assign dout_out = dout_q;
  assign flag_out = flag_q;
  assign w_out    = w_q;
  assign pc_out   = r_val[PC_IDX];

endmodule : datapath_regs

// File: tb/tb_datapath_regs.sv
// Directed bench for datapath_regs: reset, MV immediate, PC/SP counting,
// store path, flags/G, self-load hold and unused bus codes.
module tb_datapath_regs;
  import datapath_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  RX_in;
  logic        IR_in, A_in, G_in, ADDR_in, DOUT_in, flag_in;
  logic        pc_incr, sp_incr, sp_decr, W_inp;
  logic [3:0]  sel;
  logic [15:0] din, alu_result;
  logic [2:0]  alu_flags;
  logic [15:0] bus, IR_out, A_out, G_out, addr_out, dout_out, pc_out;
  logic [2:0]  flag_out;
  logic        w_out;

  int vectors = 0;
  int miscompares = 0;

  datapath_regs dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RX_in      (RX_in),
    .IR_in      (IR_in),
    .A_in       (A_in),
    .G_in       (G_in),
    .ADDR_in    (ADDR_in),
    .DOUT_in    (DOUT_in),
    .flag_in    (flag_in),
    .pc_incr    (pc_incr),
    .sp_incr    (sp_incr),
    .sp_decr    (sp_decr),
    .W_inp      (W_inp),
    .sel        (sel),
    .din        (din),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .bus        (bus),
    .IR_out     (IR_out),
    .A_out      (A_out),
    .G_out      (G_out),
    .addr_out   (addr_out),
    .dout_out   (dout_out),
    .flag_out   (flag_out),
    .w_out      (w_out),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Return every control to its inactive level.
  task automatic idle();
    reset_n = 1'b1; RX_in = 8'hFF;
    IR_in = 1'b1; A_in = 1'b1; G_in = 1'b1; ADDR_in = 1'b1; DOUT_in = 1'b1; flag_in = 1'b1;
    pc_incr = 1'b0; sp_incr = 1'b0; sp_decr = 1'b0; W_inp = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read Rn through the combinational bus.
  task automatic check_reg(input string tag, input int n, input logic [15:0] exp);
    sel = 4'(n);
    #1;
    check(tag, bus, exp);
  endtask

  initial begin
    idle();
    sel = 4'd0; din = '0; alu_result = '0; alu_flags = '0;

    // Fill everything with nonzero values, then reset with all enables active.
    sel = SEL_DIN; din = 16'h5A5A; RX_in = 8'h00;
    IR_in = 1'b0; A_in = 1'b0; ADDR_in = 1'b0; DOUT_in = 1'b0;
    G_in = 1'b0; alu_result = 16'h7777; flag_in = 1'b0; alu_flags = 3'b111; W_inp = 1'b1;
    tick();
    check("preload_A", A_out, 16'h5A5A);
    check("preload_w", {15'b0, w_out}, 16'h0001);
    check("preload_pc", pc_out, 16'h5A5A);

    reset_n = 1'b0; pc_incr = 1'b1; sp_incr = 1'b1;
    tick();
    idle();
    check("rst_IR", IR_out, 16'h0000);
    check("rst_A", A_out, 16'h0000);
    check("rst_G", G_out, 16'h0000);
    check("rst_addr", addr_out, 16'h0000);
    check("rst_dout", dout_out, 16'h0000);
    check("rst_flag", {13'b0, flag_out}, 16'h0000);
    check("rst_w", {15'b0, w_out}, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);
    for (int n = 0; n < 8; n++) check_reg($sformatf("rst_R%0d", n), n, 16'h0000);

    // MV immediate: IR from din, R2 from the 9-bit immediate.
    din = 16'h01FF; IR_in = 1'b0;
    tick();
    IR_in = 1'b1;
    check("ir_load", IR_out, 16'h01FF);
    sel = SEL_IR; RX_in = 8'hFB;
    tick();
    RX_in = 8'hFF;
    check_reg("mv_R2_01FF", 2, 16'h01FF);
    din = 16'hFE05; IR_in = 1'b0;
    tick();
    IR_in = 1'b1;
    sel = SEL_IR; #1;
    check("bus_ir_imm", bus, 16'h0005);
    RX_in = 8'hFB;
    tick();
    RX_in = 8'hFF;
    check_reg("mv_R2_0005", 2, 16'h0005);

    // PC wrap, then load beats increment, then hold.
    sel = SEL_DIN; din = 16'hFFFF; RX_in = 8'h7F;
    tick();
    RX_in = 8'hFF;
    check("pc_load_ffff", pc_out, 16'hFFFF);
    pc_incr = 1'b1;
    tick();
    check("pc_wrap", pc_out, 16'h0000);
    din = 16'h1234; RX_in = 8'h7F;
    tick();
    idle();
    check("pc_load_prio", pc_out, 16'h1234);
    tick();
    check("pc_hold", pc_out, 16'h1234);

    // SP: decrement wrap, both strobes hold, load overrides increment.
    sel = SEL_DIN; din = 16'h0000; RX_in = 8'hDF;
    tick();
    RX_in = 8'hFF; sp_decr = 1'b1;
    tick();
    check_reg("sp_dec_wrap", 5, 16'hFFFF);
    sp_incr = 1'b1;
    tick();
    check_reg("sp_both_hold", 5, 16'hFFFF);
    sp_decr = 1'b0;
    tick();
    check_reg("sp_inc_wrap", 5, 16'h0000);
    sel = SEL_DIN; din = 16'h0040; RX_in = 8'hDF;
    tick();
    idle();
    check_reg("sp_load_prio", 5, 16'h0040);
    check("pc_untouched", pc_out, 16'h1234);

    // Store path: R3 to DOUT with a one-cycle-delayed write strobe.
    sel = SEL_DIN; din = 16'hABCD; RX_in = 8'hF7;
    tick();
    RX_in = 8'hFF;
    sel = 4'd3; DOUT_in = 1'b0; W_inp = 1'b1;
    tick();
    idle();
    check("st_dout", dout_out, 16'hABCD);
    check("st_w_hi", {15'b0, w_out}, 16'h0001);
    tick();
    check("st_w_lo", {15'b0, w_out}, 16'h0000);
    check("st_dout_hold", dout_out, 16'hABCD);

    // Self-load of R3 while it drives the bus holds; multi-destination load.
    sel = 4'd3; RX_in = 8'hF6; A_in = 1'b0; ADDR_in = 1'b0;
    tick();
    idle();
    check_reg("self_R3", 3, 16'hABCD);
    check_reg("multi_R0", 0, 16'hABCD);
    check("multi_A", A_out, 16'hABCD);
    check("multi_addr", addr_out, 16'hABCD);

    // G and flags from the ALU, then hold with enables high.
    alu_result = 16'h8000;
    alu_flags = '0; alu_flags[FLAG_COUT] = 1'b1; alu_flags[FLAG_N] = 1'b1;
    G_in = 1'b0; flag_in = 1'b0;
    tick();
    idle();
    check("g_load", G_out, 16'h8000);
    check("flag_load", {13'b0, flag_out}, 16'h0006);
    alu_result = 16'h1111; alu_flags = 3'b001;
    tick();
    check("g_hold", G_out, 16'h8000);
    check("flag_hold", {13'b0, flag_out}, 16'h0006);
    sel = SEL_G; #1;
    check("bus_g", bus, 16'h8000);

    // Unused select codes drive zero.
    for (int s = 11; s < 16; s++) begin
      sel = 4'(s); #1;
      check($sformatf("bus_sel%0d", s), bus, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_datapath_regs
